// File: rtl/st_video_pkg.sv
// Shared types and constants for the Avalon-ST video capture parser.
// Covers packet type codes, the parser state encoding and the output beat payload.
package st_video_pkg;

    localparam int SYM_W         = 8;
    localparam int SYMS_PER_BEAT = 3;
    localparam int BEAT_W        = SYM_W * SYMS_PER_BEAT;

    localparam logic [3:0] PKT_VIDEO = 4'h0;
    localparam logic [3:0] PKT_CTRL  = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        CTRL,
        VIDEO,
        DROP
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } pix_t;

endpackage

// File: rtl/st_video_out_reg.sv
// One-deep valid/ready output register.
// Holds a single pixel beat for the downstream sink and tells the parser when it may accept.
module st_video_out_reg
    import st_video_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  pix_t load_pix,
    input  logic out_ready,
    output logic out_valid,
    output pix_t held_pix,
    output logic space
);

    // A new beat fits if the slot is empty or is being drained this cycle.
    assign space = out_ready | ~out_valid;

    // NOTE: state updates use <= so every flop samples pre-edge values regardless of block order.
    // NOTE: the payload is reset as well as the valid bit so the output is all zeros out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            held_pix  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            held_pix  <= load_pix;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/st_video_capture_parser.sv
// Avalon-ST Video packet parser: latches control packets and forwards pixels padded to 32 bits.
// Also counts frames and flags size and framing errors.
module st_video_capture_parser
    import st_video_pkg::*;
#(
    parameter int         FC_W = 16,
    parameter logic [7:0] PAD  = 8'h00
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              in_ready,
    input  logic              in_valid,
    input  logic [23:0]       in_data,
    input  logic              in_startofpacket,
    input  logic              in_endofpacket,
    input  logic [1:0]        in_empty,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [31:0]       out_data,
    output logic              out_startofpacket,
    output logic              out_endofpacket,
    output logic [15:0]       ctrl_width,
    output logic [15:0]       ctrl_height,
    output logic [3:0]        ctrl_interlace,
    output logic              ctrl_seen,
    output logic [FC_W-1:0]   frame_count,
    output logic              frame_done,
    output logic [1:0]        err_flags,
    input  logic              err_clear
);

    state_t      state, state_n;
    logic [1:0]  ctrl_beat;
    logic [15:0] sh_width;
    logic [7:0]  sh_height_hi;
    logic [31:0] pix_count, pix_total, frame_size;
    logic        first_pix;

    logic        accept;
    logic        fwd, frame_end, set_size, set_frame;
    logic        video_start, ctrl_start, ctrl_data, ctrl_commit;
    logic [3:0]  nib0, nib1, nib2;
    pix_t        load_pix, held_pix;

    assign accept     = in_valid & in_ready;
    assign nib0       = in_data[3:0];
    assign nib1       = in_data[SYM_W+3:SYM_W];
    assign nib2       = in_data[2*SYM_W+3:2*SYM_W];
    assign pix_total  = (pix_count == 32'hFFFF_FFFF) ? pix_count : pix_count + 32'd1;
    assign frame_size = 32'(ctrl_width) * 32'(ctrl_height);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // NOTE: every signal assigned here gets a default first so no path can infer a latch.
    always_comb begin
        state_n     = state;
        fwd         = 1'b0;
        frame_end   = 1'b0;
        set_size    = 1'b0;
        set_frame   = 1'b0;
        video_start = 1'b0;
        ctrl_start  = 1'b0;
        ctrl_data   = 1'b0;
        ctrl_commit = 1'b0;
        if (accept) begin
            if (in_startofpacket) begin
                // A header always restarts parsing; any packet in flight is abandoned.
                if (state != IDLE) set_frame = 1'b1;
                case (nib0)
                    PKT_VIDEO: begin
                        video_start = 1'b1;
                        state_n     = in_endofpacket ? IDLE : VIDEO;
                        set_size    = in_endofpacket & ctrl_seen;
                    end
                    PKT_CTRL: begin
                        ctrl_start = 1'b1;
                        state_n    = in_endofpacket ? IDLE : CTRL;
                    end
                    default: state_n = in_endofpacket ? IDLE : DROP;
                endcase
            end else begin
                case (state)
                    CTRL: begin
                        if (ctrl_beat != 2'd3) begin
                            ctrl_data = 1'b1;
                            if (ctrl_beat == 2'd2)   ctrl_commit = 1'b1;
                            else if (in_endofpacket) set_frame   = 1'b1;
                        end
                        if (in_endofpacket) state_n = IDLE;
                    end
                    VIDEO: begin
                        fwd = 1'b1;
                        if (in_endofpacket) begin
                            frame_end = 1'b1;
                            set_size  = ctrl_seen & (pix_total != frame_size);
                            set_frame = (in_empty != 2'd0);
                            state_n   = IDLE;
                        end
                    end
                    DROP: if (in_endofpacket) state_n = IDLE;
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_beat      <= 2'd0;
            sh_width       <= 16'd0;
            sh_height_hi   <= 8'd0;
            ctrl_width     <= 16'd0;
            ctrl_height    <= 16'd0;
            ctrl_interlace <= 4'd0;
            ctrl_seen      <= 1'b0;
        end else if (ctrl_start) begin
            ctrl_beat    <= 2'd0;
            sh_width     <= 16'd0;
            sh_height_hi <= 8'd0;
        end else if (ctrl_data) begin
            ctrl_beat <= ctrl_beat + 2'd1;
            case (ctrl_beat)
                2'd0: sh_width[15:4] <= {nib0, nib1, nib2};
                2'd1: begin
                    sh_width[3:0] <= nib0;
                    sh_height_hi  <= {nib1, nib2};
                end
                default: ;
            endcase
            // The last beat is committed directly so all three fields change together.
            if (ctrl_commit) begin
                ctrl_width     <= sh_width;
                ctrl_height    <= {sh_height_hi, nib0, nib1};
                ctrl_interlace <= nib2;
                ctrl_seen      <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_count <= 32'd0;
            first_pix <= 1'b0;
        end else if (video_start) begin
            pix_count <= 32'd0;
            first_pix <= 1'b1;
        end else if (fwd) begin
            pix_count <= pix_total;
            first_pix <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_done  <= 1'b0;
            frame_count <= '0;
            err_flags   <= 2'b00;
        end else begin
            frame_done <= frame_end;
            if (frame_end) frame_count <= frame_count + FC_W'(1);
            err_flags <= (err_clear ? 2'b00 : err_flags) | {set_frame, set_size};
        end
    end

    assign load_pix = '{data: {PAD, in_data}, sop: first_pix, eop: in_endofpacket};

    st_video_out_reg u_out_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (fwd),
        .load_pix  (load_pix),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .held_pix  (held_pix),
        .space     (in_ready)
    );

    assign out_data          = held_pix.data;
    assign out_startofpacket = held_pix.sop;
    assign out_endofpacket   = held_pix.eop;

endmodule

// File: tb/tb_st_video_capture_parser.sv
// Scoreboard bench for st_video_capture_parser: the driver queues expected pixels,
// a monitor pops and compares every handshaken output beat.
module tb_st_video_capture_parser;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_ready, in_valid, in_startofpacket, in_endofpacket;
    logic [23:0] in_data;
    logic [1:0]  in_empty;
    logic        out_ready, out_valid, out_startofpacket, out_endofpacket;
    logic [31:0] out_data;
    logic [15:0] ctrl_width, ctrl_height;
    logic [3:0]  ctrl_interlace;
    logic        ctrl_seen, frame_done, err_clear;
    logic [15:0] frame_count;
    logic [1:0]  err_flags;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   fd_count = 0;

    st_video_capture_parser #(.FC_W(16), .PAD(8'h00)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_ready          (in_ready),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .in_empty          (in_empty),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .ctrl_width        (ctrl_width),
        .ctrl_height       (ctrl_height),
        .ctrl_interlace    (ctrl_interlace),
        .ctrl_seen         (ctrl_seen),
        .frame_count       (frame_count),
        .frame_done        (frame_done),
        .err_flags         (err_flags),
        .err_clear         (err_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: samples mid-cycle, after all inputs for the coming edge are settled.
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = 32'd0;
    always @(negedge clk) begin
        #2;
        if (reset_n) begin
            if (frame_done) fd_count++;
            if (prev_hold) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: data %h with nothing expected", out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_sop", out_startofpacket, e.sop);
                    check("out_eop", out_endofpacket, e.eop);
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    task automatic send(input logic [23:0] d, input logic sop, input logic eop,
                        input logic [1:0] emp, input logic fwd, input logic fsop,
                        input logic clr);
        int   guard;
        logic ok;
        exp_t e;
        @(negedge clk);
        in_valid         = 1'b1;
        in_data          = d;
        in_startofpacket = sop;
        in_endofpacket   = eop;
        in_empty         = emp;
        err_clear        = clr;
        guard            = 0;
        ok               = 1'b0;
        forever begin
            #1;
            ok = in_ready;
            @(posedge clk);
            if (ok) break;
            guard++;
            if (guard > 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: beat %h never accepted", d);
                break;
            end
            @(negedge clk);
        end
        if (ok && fwd) begin
            e = '{data: {8'h00, d}, sop: fsop, eop: eop};
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid         = 1'b0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
        in_empty         = 2'd0;
        err_clear        = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic send_ctrl(input logic [23:0] b1, input logic [23:0] b2, input logic [23:0] b3);
        send(24'h00000F, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        send(b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        send(b2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        send(b3, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input bit hdr, input int n, input logic [23:0] base,
                              input logic [1:0] emp_last, input logic clr_last);
        logic last;
        if (hdr) send(24'h000000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1);
            send(24'(base + i * 24'h010101), 1'b0, last, last ? emp_last : 2'd0,
                 1'b1, (i == 0), last ? clr_last : 1'b0);
        end
    endtask

    task automatic clear_errors();
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        #1;
        check("err_after_clear", err_flags, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0; in_data = 24'd0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
        in_empty = 2'd0; out_ready = 1'b1; err_clear = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_frame_count", frame_count, 16'd0);
        check("rst_err_flags", err_flags, 2'b00);
        check("rst_ctrl_seen", ctrl_seen, 1'b0);
        check("rst_ctrl_width", ctrl_width, 16'd0);
        check("rst_frame_done", frame_done, 1'b0);

        // 320 x 240, interlace 2: nibbles go symbol0, symbol1, symbol2 in order.
        send_ctrl(24'h040100, 24'h000000, 24'h02000F);
        idle(3);
        check("ctrl_width_320", ctrl_width, 16'h0140);
        check("ctrl_height_240", ctrl_height, 16'h00F0);
        check("ctrl_interlace_2", ctrl_interlace, 4'h2);
        check("ctrl_seen", ctrl_seen, 1'b1);

        send_ctrl(24'h000000, 24'h000004, 24'h000200);
        idle(3);
        check("ctrl_width_4", ctrl_width, 16'd4);
        check("ctrl_height_2", ctrl_height, 16'd2);
        check("ctrl_interlace_0", ctrl_interlace, 4'h0);

        send_frame(1'b1, 8, 24'h112233, 2'd0, 1'b0);
        idle(4);
        check("f1_frame_count", frame_count, 16'd1);
        check("f1_frame_done", fd_count, 1);
        check("f1_err", err_flags, 2'b00);

        fork
            send_frame(1'b1, 8, 24'h445566, 2'd0, 1'b0);
            begin
                repeat (5) @(negedge clk);
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                #1;
                check("stall_in_ready", in_ready, 1'b0);
                repeat (2) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        idle(4);
        check("f2_frame_count", frame_count, 16'd2);
        check("f2_frame_done", fd_count, 2);
        check("f2_err", err_flags, 2'b00);
        check("f2_queue_drained", exp_q.size(), 0);

        send_frame(1'b1, 7, 24'h202020, 2'd0, 1'b0);
        idle(4);
        check("f3_size_err", err_flags, 2'b01);
        check("f3_frame_count", frame_count, 16'd3);
        clear_errors();

        send_frame(1'b1, 5, 24'h303030, 2'd0, 1'b1);
        idle(4);
        check("f4_set_beats_clear", err_flags, 2'b01);
        check("f4_frame_count", frame_count, 16'd4);
        clear_errors();

        send(24'h000000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        send(24'h600000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        send(24'h600001, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        send(24'h000000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        idle(3);
        check("abandon_err", err_flags, 2'b10);
        check("abandon_frame_count", frame_count, 16'd4);
        check("abandon_frame_done", fd_count, 4);
        send_frame(1'b0, 8, 24'h700000, 2'd0, 1'b0);
        idle(4);
        check("f5_frame_count", frame_count, 16'd5);
        check("f5_frame_done", fd_count, 5);
        check("f5_err", err_flags, 2'b10);
        clear_errors();

        send(24'h000005, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        send(24'h111111, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        send(24'h222222, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        send(24'h333333, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        send(24'hABCDEF, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        send(24'hFEDCBA, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        idle(4);
        check("drop_frame_count", frame_count, 16'd5);
        check("drop_frame_done", fd_count, 5);
        check("drop_err", err_flags, 2'b00);

        send(24'h00000F, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        send(24'h0F0F0F, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        idle(3);
        check("ctrl_trunc_err", err_flags, 2'b10);
        check("ctrl_trunc_width", ctrl_width, 16'd4);
        check("ctrl_trunc_height", ctrl_height, 16'd2);
        clear_errors();

        send(24'h000000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        idle(3);
        check("empty_video_err", err_flags, 2'b01);
        check("empty_video_frame_count", frame_count, 16'd5);
        clear_errors();

        send_frame(1'b1, 8, 24'h505050, 2'd2, 1'b0);
        idle(4);
        check("in_empty_err", err_flags, 2'b10);
        check("in_empty_frame_count", frame_count, 16'd6);
        check("final_queue_empty", exp_q.size(), 0);

        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("reset_ctrl_seen", ctrl_seen, 1'b0);
        check("reset_ctrl_width", ctrl_width, 16'd0);
        check("reset_frame_count", frame_count, 16'd0);
        check("reset_err_flags", err_flags, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
